// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use interlock, memory-wait freeze and branch flush control
module hazard_stall_unit #(
    parameter int REGADDR_WIDTH = 5,
    parameter int CNT_WIDTH     = 32,
    parameter int MEM_TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REGADDR_WIDTH-1:0] id_rs_addr,
    input  logic [REGADDR_WIDTH-1:0] id_rt_addr,
    input  logic                     id_uses_rs,
    input  logic                     id_uses_rt,
    input  logic                     id_branch_taken,
    input  logic                     id2ex_is_load,
    input  logic [REGADDR_WIDTH-1:0] id2ex_wb_reg_addr,
    input  logic                     ex2mem_is_load,
    input  logic [REGADDR_WIDTH-1:0] ex2mem_wb_reg_addr,
    input  logic                     mem_req,
    input  logic                     mem_ack,
    input  logic                     err_clr,
    output logic                     pc_stall,
    output logic                     if2id_stall,
    output logic                     if2id_flush,
    output logic                     id2ex_stall,
    output logic                     id2ex_bubble,
    output logic                     ex2mem_stall,
    output logic                     mem2wb_bubble,
    output logic [CNT_WIDTH-1:0]     stall_cycles,
    output logic                     mem_err
);

    // Wait counter only has to reach MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  mem_err_q, mem_err_d;
    logic [CNT_WIDTH-1:0]  stall_cycles_q, stall_cycles_d;

    logic match_ex;
    logic match_mem;
    logic lu;
    logic mw;
    logic timeout;

    // Load-use detection against loads sitting in EX and in MEM; r0 never hazards.
    always_comb begin
        match_ex  = id2ex_is_load && (id2ex_wb_reg_addr != '0) &&
                    ((id_uses_rs && (id_rs_addr == id2ex_wb_reg_addr)) ||
                     (id_uses_rt && (id_rt_addr == id2ex_wb_reg_addr)));
        match_mem = ex2mem_is_load && (ex2mem_wb_reg_addr != '0) &&
                    ((id_uses_rs && (id_rs_addr == ex2mem_wb_reg_addr)) ||
                     (id_uses_rt && (id_rt_addr == ex2mem_wb_reg_addr)));
        lu        = match_ex || match_mem;
        mw        = ((state_q == MEM_WAIT) || mem_req) && !mem_ack;
    end

    // State register, wait counter, sticky error and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Next state: ack always releases, even on the timeout cycle, so ack beats timeout.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req && !mem_ack) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        mem_err_d      = timeout || (mem_err_q && !err_clr);
        stall_cycles_d = (pc_stall && (stall_cycles_q != '1)) ?
                         stall_cycles_q + CNT_WIDTH'(1) : stall_cycles_q;
    end

    // Outputs by priority: memory freeze, then load-use, then branch flush; all low in reset.
    always_comb begin
        pc_stall      = 1'b0;
        if2id_stall   = 1'b0;
        if2id_flush   = 1'b0;
        id2ex_stall   = 1'b0;
        id2ex_bubble  = 1'b0;
        ex2mem_stall  = 1'b0;
        mem2wb_bubble = 1'b0;
        if (rst_n) begin
            if (mw) begin
                pc_stall      = 1'b1;
                if2id_stall   = 1'b1;
                id2ex_stall   = 1'b1;
                ex2mem_stall  = 1'b1;
                mem2wb_bubble = 1'b1;
            end else if (lu) begin
                pc_stall      = 1'b1;
                if2id_stall   = 1'b1;
                id2ex_bubble  = 1'b1;
            end else if (id_branch_taken) begin
                if2id_flush   = 1'b1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign mem_err      = mem_err_q;

endmodule
